// File: rtl/cpu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | cpu_pkg : shared ALU opcodes and EX-stage FSM state encoding              |
// | Revision: 1.0                                                             |
// ----------------------------------------------------------------------------
package cpu_pkg;

  localparam logic [3:0] c_alu_add   = 4'd0;
  localparam logic [3:0] c_alu_sub   = 4'd1;
  localparam logic [3:0] c_alu_and   = 4'd2;
  localparam logic [3:0] c_alu_or    = 4'd3;
  localparam logic [3:0] c_alu_xor   = 4'd4;
  localparam logic [3:0] c_alu_sll   = 4'd5;
  localparam logic [3:0] c_alu_srl   = 4'd6;
  localparam logic [3:0] c_alu_sra   = 4'd7;
  localparam logic [3:0] c_alu_slt   = 4'd8;
  localparam logic [3:0] c_alu_sltu  = 4'd9;
  localparam logic [3:0] c_alu_passb = 4'd10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } ex_state_t;

endpackage
`default_nettype wire

// File: rtl/ex_alu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | ex_alu : combinational integer ALU for the EX stage                       |
// | Revision: 1.0                                                             |
// ----------------------------------------------------------------------------
module ex_alu
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] y
);

  localparam int c_SHW = $clog2(XLEN);

  logic [c_SHW-1:0] w_shamt;
  logic             w_lt_s;
  logic             w_lt_u;

  assign w_shamt = b[c_SHW-1:0];
  assign w_lt_s  = $signed(a) < $signed(b);
  assign w_lt_u  = a < b;

  always_comb begin
    y = '0;
    case (op)
      c_alu_add:   y = a + b;
      c_alu_sub:   y = a - b;
      c_alu_and:   y = a & b;
      c_alu_or:    y = a | b;
      c_alu_xor:   y = a ^ b;
      c_alu_sll:   y = a << w_shamt;
      c_alu_srl:   y = a >> w_shamt;
      c_alu_sra:   y = $unsigned($signed(a) >>> w_shamt);
      c_alu_slt:   y = {{(XLEN-1){1'b0}}, w_lt_s};
      c_alu_sltu:  y = {{(XLEN-1){1'b0}}, w_lt_u};
      c_alu_passb: y = b;
      default:     y = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | execute_stage : EX stage with single-cycle ALU and stalled CNN path       |
// | Revision: 1.0                                                             |
// ----------------------------------------------------------------------------
module execute_stage
  import cpu_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              CNN_TIMEOUT = 4096,
  parameter logic [XLEN-1:0] CNN_ERR_VAL = '1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            id_valid,
  input  logic [3:0]      id_alu_op,
  input  logic [XLEN-1:0] id_rs1_val,
  input  logic [XLEN-1:0] id_rs2_val,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_use_imm,
  input  logic [4:0]      id_rd,
  input  logic            id_is_cnn,
  output logic            ex_stall,
  output logic            cnn_start,
  output logic [XLEN-1:0] cnn_arg,
  input  logic            cnn_done,
  input  logic [XLEN-1:0] cnn_result,
  output logic            cnn_err,
  output logic [XLEN-1:0] ex_val,
  output logic [XLEN-1:0] ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            ex_valid,
  output logic            ex_is_cnn
);

  localparam int               c_CW       = $clog2(CNN_TIMEOUT);
  localparam logic [c_CW-1:0]  c_CNT_LAST = c_CW'(CNN_TIMEOUT - 1);

  ex_state_t       r_state, w_state_nxt;
  logic [c_CW-1:0] r_cnt, w_cnt_nxt;
  logic [4:0]      r_cnn_rd, w_cnn_rd_nxt;
  logic [XLEN-1:0] r_cnn_rs2, w_cnn_rs2_nxt;

  logic            w_start_nxt, w_err_nxt, w_valid_nxt, w_is_cnn_nxt;
  logic [XLEN-1:0] w_arg_nxt, w_val_nxt, w_rs2_nxt;
  logic [4:0]      w_rd_nxt;
  logic [XLEN-1:0] w_alu_b, w_alu_y;

  assign w_alu_b  = id_use_imm ? id_imm : id_rs2_val;
  assign ex_stall = (r_state == ST_WAIT);

  ex_alu #(.XLEN(XLEN)) u_alu (
    .a  (id_rs1_val),
    .b  (w_alu_b),
    .op (id_alu_op),
    .y  (w_alu_y)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_cnn_rd_nxt  = r_cnn_rd;
    w_cnn_rs2_nxt = r_cnn_rs2;
    w_start_nxt   = 1'b0;
    w_arg_nxt     = cnn_arg;
    w_err_nxt     = cnn_err;
    w_val_nxt     = ex_val;
    w_rs2_nxt     = ex_rs2;
    w_rd_nxt      = ex_rd;
    w_valid_nxt   = 1'b0;
    w_is_cnn_nxt  = ex_is_cnn;
    case (r_state)
      ST_IDLE: begin
        if (id_valid && id_is_cnn) begin
          w_state_nxt   = ST_WAIT;
          w_cnt_nxt     = '0;
          w_start_nxt   = 1'b1;
          w_arg_nxt     = id_rs1_val;
          w_cnn_rd_nxt  = id_rd;
          w_cnn_rs2_nxt = id_rs2_val;
        end else if (id_valid) begin
          w_val_nxt    = w_alu_y;
          w_rs2_nxt    = id_rs2_val;
          w_rd_nxt     = id_rd;
          w_valid_nxt  = 1'b1;
          w_is_cnn_nxt = 1'b0;
        end
      end
      ST_WAIT: begin
        // A result arriving on the timeout cycle still counts as a success.
        if (cnn_done || (r_cnt == c_CNT_LAST)) begin
          w_state_nxt  = ST_IDLE;
          w_val_nxt    = cnn_done ? cnn_result : CNN_ERR_VAL;
          w_err_nxt    = cnn_err | ~cnn_done;
          w_rs2_nxt    = r_cnn_rs2;
          w_rd_nxt     = r_cnn_rd;
          w_valid_nxt  = 1'b1;
          w_is_cnn_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_CW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_cnn_rd  <= '0;
      r_cnn_rs2 <= '0;
      cnn_start <= 1'b0;
      cnn_arg   <= '0;
      cnn_err   <= 1'b0;
      ex_val    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_valid  <= 1'b0;
      ex_is_cnn <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_cnn_rd  <= w_cnn_rd_nxt;
      r_cnn_rs2 <= w_cnn_rs2_nxt;
      cnn_start <= w_start_nxt;
      cnn_arg   <= w_arg_nxt;
      cnn_err   <= w_err_nxt;
      ex_val    <= w_val_nxt;
      ex_rs2    <= w_rs2_nxt;
      ex_rd     <= w_rd_nxt;
      ex_valid  <= w_valid_nxt;
      ex_is_cnn <= w_is_cnn_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | tb_execute_stage : directed bench for execute_stage with reference model  |
// | Revision: 1.0                                                             |
// ----------------------------------------------------------------------------
module tb_execute_stage;

  localparam int          c_TMO = 16;
  localparam logic [31:0] c_ERR = 32'hFFFF_FFFF;

  logic        clk;
  logic        reset_n;
  logic        id_valid, id_use_imm, id_is_cnn, cnn_done;
  logic [3:0]  id_alu_op;
  logic [31:0] id_rs1_val, id_rs2_val, id_imm, cnn_result;
  logic [4:0]  id_rd;
  logic        ex_stall, cnn_start, cnn_err, ex_valid, ex_is_cnn;
  logic [31:0] cnn_arg, ex_val, ex_rs2;
  logic [4:0]  ex_rd;

  int n_cmp  = 0;
  int n_fail = 0;

  execute_stage #(.XLEN(32), .CNN_TIMEOUT(c_TMO), .CNN_ERR_VAL(c_ERR)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_rd(id_rd), .id_is_cnn(id_is_cnn),
    .ex_stall(ex_stall), .cnn_start(cnn_start), .cnn_arg(cnn_arg),
    .cnn_done(cnn_done), .cnn_result(cnn_result), .cnn_err(cnn_err),
    .ex_val(ex_val), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_valid(ex_valid),
    .ex_is_cnn(ex_is_cnn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return a << sh;
      6:  return a >> sh;
      7:  return (a >> sh) | ((a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      8:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      9:  return (a < b) ? 32'd1 : 32'd0;
      10: return b;
      default: return 32'd0;
    endcase
  endfunction

  // Reference model: what the output slot must hold after each edge.
  logic        m_busy, m_start, m_err, m_fresh, m_is_cnn;
  int          m_waited;
  logic [31:0] m_arg, m_val, m_rs2, m_crs2;
  logic [4:0]  m_rd, m_crd;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 0; m_start <= 0; m_err <= 0; m_fresh <= 0; m_is_cnn <= 0;
      m_waited <= 0; m_arg <= 0; m_val <= 0; m_rs2 <= 0; m_crs2 <= 0;
      m_rd <= 0; m_crd <= 0;
    end else begin
      m_fresh <= 0;
      m_start <= 0;
      if (!m_busy) begin
        if (id_valid && !id_is_cnn) begin
          m_fresh  <= 1;
          m_val    <= ref_alu(int'(id_alu_op), id_rs1_val, id_use_imm ? id_imm : id_rs2_val);
          m_rs2    <= id_rs2_val;
          m_rd     <= id_rd;
          m_is_cnn <= 0;
        end else if (id_valid) begin
          m_busy   <= 1;
          m_start  <= 1;
          m_waited <= 0;
          m_arg    <= id_rs1_val;
          m_crd    <= id_rd;
          m_crs2   <= id_rs2_val;
        end
      end else begin
        m_waited <= m_waited + 1;
        if (cnn_done || (m_waited + 1 == c_TMO)) begin
          m_busy   <= 0;
          m_fresh  <= 1;
          m_val    <= cnn_done ? cnn_result : c_ERR;
          m_rd     <= m_crd;
          m_rs2    <= m_crs2;
          m_is_cnn <= 1;
          if (!cnn_done) m_err <= 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_stall", ex_stall, 0);
      chk("rst_valid", ex_valid, 0);
      chk("rst_val",   ex_val,   0);
      chk("rst_err",   cnn_err,  0);
    end else begin
      chk("stall", ex_stall,  m_busy);
      chk("start", cnn_start, m_start);
      chk("err",   cnn_err,   m_err);
      chk("valid", ex_valid,  m_fresh);
      if (m_fresh) begin
        chk("val",    ex_val,    m_val);
        chk("rd",     ex_rd,     m_rd);
        chk("rs2",    ex_rs2,    m_rs2);
        chk("is_cnn", ex_is_cnn, m_is_cnn);
      end
      if (m_busy) chk("arg", cnn_arg, m_arg);
    end
  end

  task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] imm, input logic ui, input logic [4:0] rd,
                     input logic [31:0] lit, input string nm);
    id_valid = 1; id_is_cnn = 0; id_alu_op = op; id_rs1_val = a; id_rs2_val = b;
    id_imm = imm; id_use_imm = ui; id_rd = rd;
    @(posedge clk); #1;
    id_valid = 0;
    chk(nm, ex_val, lit);
    chk({nm, "_valid"}, ex_valid, 1);
  endtask

  // Holds the CNN op on the ID inputs while stalled; done_after = WAIT cycles before done.
  task automatic cnn(input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] rd,
                     input int done_after, input logic [31:0] res,
                     output int stall_cyc, output int start_cyc);
    id_valid = 1; id_is_cnn = 1; id_alu_op = 4'd0; id_rs1_val = rs1;
    id_rs2_val = rs2; id_rd = rd; id_use_imm = 0;
    stall_cyc = 0; start_cyc = 0;
    @(posedge clk); #1;
    for (int k = 1; k <= 200; k++) begin
      if (!ex_stall) break;
      stall_cyc++;
      if (cnn_start) start_cyc++;
      if (k == done_after + 1) begin cnn_done = 1; cnn_result = res; end
      @(posedge clk); #1;
      cnn_done = 0;
    end
    id_valid = 0; id_is_cnn = 0;
  endtask

  int st, sc;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0; id_valid = 0; id_alu_op = 0; id_rs1_val = 0; id_rs2_val = 0;
    id_imm = 0; id_use_imm = 0; id_rd = 0; id_is_cnn = 0; cnn_done = 0; cnn_result = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    chk("reset_ex_valid", ex_valid, 0);
    chk("reset_ex_stall", ex_stall, 0);
    chk("reset_cnn_err",  cnn_err,  0);

    alu(4'd0, 32'd5, 32'd7, 32'd0, 0, 5'd1, 32'd12, "add");
    chk("add_is_cnn", ex_is_cnn, 0);
    chk("add_stall",  ex_stall,  0);

    alu(4'd1,  32'd0,          32'd1,          32'd0,  0, 5'd2, 32'hFFFF_FFFF, "sub");
    alu(4'd7,  32'h8000_0000,  32'd0,          32'd4,  1, 5'd3, 32'hF800_0000, "sra");
    alu(4'd8,  32'hFFFF_FFFF,  32'd1,          32'd0,  0, 5'd4, 32'd1,         "slt");
    alu(4'd9,  32'hFFFF_FFFF,  32'd1,          32'd0,  0, 5'd5, 32'd0,         "sltu");
    alu(4'd15, 32'd3,          32'd4,          32'd0,  0, 5'd6, 32'd0,         "op15");
    alu(4'd0,  32'hFFFF_FFFF,  32'd2,          32'd0,  0, 5'd7, 32'd1,         "add_wrap");
    alu(4'd2,  32'h0000_F0F0,  32'h0000_0FF0,  32'd0,  0, 5'd8, 32'h0000_00F0, "and");
    alu(4'd3,  32'h0000_F0F0,  32'h0000_0FF0,  32'd0,  0, 5'd8, 32'h0000_FFF0, "or");
    alu(4'd4,  32'h0000_F0F0,  32'h0000_0FF0,  32'd0,  0, 5'd8, 32'h0000_FF00, "xor");
    alu(4'd5,  32'd1,          32'd0,          32'd31, 1, 5'd0, 32'h8000_0000, "sll");
    alu(4'd6,  32'h8000_0000,  32'd33,         32'd0,  0, 5'd9, 32'h4000_0000, "srl");
    alu(4'd10, 32'd9,          32'd5,          32'h1234, 1, 5'd10, 32'h1234,   "passb");
    @(posedge clk); #1;
    chk("idle_valid", ex_valid, 0);

    cnn(32'h100, 32'h55, 5'd9, 10, 32'd3, st, sc);
    chk("cnn_stall_cycles", st, 11);
    chk("cnn_start_cycles", sc, 1);
    chk("cnn_val", ex_val, 3);
    chk("cnn_rd", ex_rd, 9);
    chk("cnn_is_cnn", ex_is_cnn, 1);
    chk("cnn_valid", ex_valid, 1);
    @(posedge clk); #1;
    chk("cnn_valid_once", ex_valid, 0);

    cnn(32'h200, 32'h66, 5'd11, c_TMO - 1, 32'd7, st, sc);
    chk("tie_stall_cycles", st, c_TMO);
    chk("tie_val", ex_val, 7);
    chk("tie_err", cnn_err, 0);

    cnn(32'h300, 32'h77, 5'd12, 1000, 32'd0, st, sc);
    chk("tmo_stall_cycles", st, c_TMO);
    chk("tmo_val", ex_val, c_ERR);
    chk("tmo_valid", ex_valid, 1);
    chk("tmo_err", cnn_err, 1);
    alu(4'd0, 32'd20, 32'd22, 32'd0, 0, 5'd13, 32'd42, "after_tmo");
    chk("tmo_err_sticky", cnn_err, 1);

    id_valid = 1; id_is_cnn = 1; id_rs1_val = 32'h400; id_rd = 5'd14;
    @(posedge clk); #1;
    repeat (4) begin @(posedge clk); #1; end
    chk("pre_rst_stall", ex_stall, 1);
    #2 reset_n = 0; id_valid = 0; id_is_cnn = 0;
    #1;
    chk("mid_rst_stall", ex_stall, 0);
    chk("mid_rst_start", cnn_start, 0);
    chk("mid_rst_arg",   cnn_arg, 0);
    chk("mid_rst_err",   cnn_err, 0);
    chk("mid_rst_val",   ex_val, 0);
    chk("mid_rst_rd",    ex_rd, 0);
    chk("mid_rst_rs2",   ex_rs2, 0);
    chk("mid_rst_cnn",   ex_is_cnn, 0);
    @(posedge clk); #1;
    reset_n = 1; cnn_done = 1; cnn_result = 32'd5;
    @(posedge clk); #1;
    cnn_done = 0;
    chk("late_done_valid", ex_valid, 0);
    chk("late_done_stall", ex_stall, 0);

    alu(4'd0, 32'd1, 32'd2, 32'd0, 0, 5'd4, 32'd3, "b2b_add1");
    cnn(32'h500, 32'h88, 5'd5, 2, 32'hAA, st, sc);
    chk("b2b_cnn_val", ex_val, 32'hAA);
    chk("b2b_cnn_rd", ex_rd, 5);
    alu(4'd0, 32'd10, 32'd20, 32'd0, 0, 5'd6, 32'd30, "b2b_add2");
    chk("b2b_add2_rd", ex_rd, 6);
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
